sr_dmem_unit: RTL and testbench

- Data-memory stage directly downstream of the single-cycle CPU core.
- Consumes the core's data-memory request (address, write data, write enable, access size, sign) and returns load data in the same cycle.
- Contains a byte-lane-writable RAM and a small memory-mapped IO window: GPIO out/in, a free-running timer, and a store-fault status register.
- Performs load extraction and sign/zero extension, so the core sees the final load value.

---
 rtl/sr_dmem_if.sv | 22 ++
 rtl/sr_dmem_unit.sv | 121 ++++++++++++
 tb/tb_sr_dmem_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sr_dmem_if.sv
// Data-memory request/response bundle between the CPU core and sr_dmem_unit.
// The core drives the request as master; the memory stage returns load data as slave.
interface sr_dmem_if;
   logic [31:0] dmAddr;
   logic [31:0] dmDataW;
   logic        dmWe;
   logic        w_byte;
   logic        w_half;
   logic        w_word;
   logic        sign;
   logic [31:0] dmDataR;

   modport master (
      output dmAddr, dmDataW, dmWe, w_byte, w_half, w_word, sign,
      input  dmDataR
   );

   modport slave (
      input  dmAddr, dmDataW, dmWe, w_byte, w_half, w_word, sign,
      output dmDataR
   );
endinterface

// File: rtl/sr_dmem_unit.sv
// Data-memory stage: byte-lane RAM plus GPIO/timer/status IO window, with
// combinational load extraction and registered stores.
module sr_dmem_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int GPIO_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sr_dmem_if.slave              bus,
   output logic [GPIO_WIDTH-1:0] gpioOut,
   input  logic [GPIO_WIDTH-1:0] gpioIn
);

   logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];
   logic [GPIO_WIDTH-1:0] r_gpio_out;
   logic [GPIO_WIDTH-1:0] r_sync1;
   logic [GPIO_WIDTH-1:0] r_sync2;
   logic [31:0]           r_timer;
   logic                  r_fault;
   logic [7:0]            r_count;

   logic [31:0]           w_addr;
   logic                  w_is_byte, w_is_half, w_is_word;
   logic                  w_aligned, w_unmapped, w_ram_sel, w_io_sel;
   logic [ADDR_WIDTH-1:0] w_ram_idx;
   logic                  w_ram_we, w_io_we, w_fault_st;
   logic                  w_gpio_we, w_timer_we, w_status_we;
   logic [31:0]           w_io_rd, w_raw;
   logic                  w_unused;

   function automatic logic [31:0] extract(input logic [31:0] raw, input logic [1:0] lane,
                                           input logic is_byte, input logic is_half,
                                           input logic sgn);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        res;
      b = raw[{lane, 3'b000} +: 8];
      h = lane[1] ? raw[31:16] : raw[15:0];
      if (is_byte)      res = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      else if (is_half) res = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      else              res = raw;
      return res;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_addr     = bus.dmAddr;
   assign w_is_byte  = bus.w_byte;
   assign w_is_half  = ~bus.w_byte & bus.w_half;
   assign w_is_word  = ~bus.w_byte & ~bus.w_half;
   assign w_aligned  = w_is_byte | (w_is_half & ~w_addr[0]) |
                       (w_is_word & (w_addr[1:0] == 2'b00));
   assign w_unmapped = |w_addr[31:16];
   assign w_ram_sel  = ~w_unmapped & ~w_addr[15];
   assign w_io_sel   = ~w_unmapped & w_addr[15];
   assign w_ram_idx  = w_addr[ADDR_WIDTH+1:2];

   // IO registers accept only aligned word stores; misaligned stores to unmapped space are silent
   assign w_ram_we    = bus.dmWe & w_aligned & w_ram_sel;
   assign w_io_we     = bus.dmWe & w_aligned & w_io_sel & w_is_word;
   assign w_fault_st  = bus.dmWe & ~w_aligned & ~w_unmapped;
   assign w_gpio_we   = w_io_we & (w_addr[3:2] == 2'd0);
   assign w_timer_we  = w_io_we & (w_addr[3:2] == 2'd2);
   assign w_status_we = w_io_we & (w_addr[3:2] == 2'd3);
   assign w_unused    = ^{w_addr[14:4], bus.w_word};

   always_comb begin
      w_io_rd = 32'b0;
      case (w_addr[3:2])
         2'd0:    w_io_rd = 32'(r_gpio_out);
         2'd1:    w_io_rd = 32'(r_sync2);
         2'd2:    w_io_rd = r_timer;
         default: w_io_rd = {16'b0, r_count, 7'b0, r_fault};
      endcase
   end

   assign w_raw       = w_ram_sel ? r_mem[w_ram_idx] : w_io_rd;
   assign bus.dmDataR = (w_aligned & ~w_unmapped) ?
                        extract(w_raw, w_addr[1:0], w_is_byte, w_is_half, bus.sign) : 32'b0;
   assign gpioOut     = r_gpio_out;

   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         if (w_is_byte)
            r_mem[w_ram_idx][{w_addr[1:0], 3'b000} +: 8] <= bus.dmDataW[7:0];
         else if (w_is_half && w_addr[1])
            r_mem[w_ram_idx][31:16] <= bus.dmDataW[15:0];
         else if (w_is_half)
            r_mem[w_ram_idx][15:0] <= bus.dmDataW[15:0];
         else
            r_mem[w_ram_idx] <= bus.dmDataW;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gpio_out <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_timer    <= 32'b0;
         r_fault    <= 1'b0;
         r_count    <= 8'b0;
      end else begin
         r_sync1 <= gpioIn;
         r_sync2 <= r_sync1;
         if (w_gpio_we) r_gpio_out <= bus.dmDataW[GPIO_WIDTH-1:0];
         // A timer write wins over the increment so the written value is visible for one cycle
         r_timer <= w_timer_we ? bus.dmDataW : r_timer + 32'd1;
         if (w_status_we) begin
            r_fault <= 1'b0;
            r_count <= 8'b0;
         end else if (w_fault_st) begin
            r_fault <= 1'b1;
            r_count <= sat_inc(r_count);
         end
      end
   end

endmodule

// File: tb/tb_sr_dmem_unit.sv
// Self-checking bench for sr_dmem_unit: vector table plus hand-written
// sequences for timer, GPIO synchronizer, mid-run reset and unmapped space.
module tb_sr_dmem_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] gpioOut;
   logic [15:0] gpioIn = 16'h0;

   sr_dmem_if bus ();

   sr_dmem_unit #(.ADDR_WIDTH(8), .GPIO_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .gpioOut(gpioOut), .gpioIn(gpioIn)
   );

   always #5 clk = ~clk;

   localparam logic [2:0] SZ_B = 3'b100, SZ_H = 3'b010, SZ_W = 3'b001, SZ_N = 3'b000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [2:0]  sz;
      logic        sg;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   string       nm_q[$];
   int          n_pass = 0;
   int          n_total = 0;

   task automatic add(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [2:0] sz, input logic sg, input logic chk,
                      input logic [31:0] e);
      vec_t v;
      v.addr = a; v.wdata = d; v.we = we; v.sz = sz; v.sg = sg; v.chk = chk; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [2:0] sz, input logic sg);
      bus.dmAddr  = a;
      bus.dmDataW = d;
      bus.dmWe    = we;
      bus.w_byte  = sz[2];
      bus.w_half  = sz[1];
      bus.w_word  = sz[0];
      bus.sign    = sg;
   endtask

   task automatic check_val(input logic [31:0] act, input logic [31:0] e, input string nm);
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, e);
   endtask

   // Expected load value is queued when the request is driven, then popped once the output settles
   task automatic expect_r(input logic [31:0] e, input string nm);
      logic [31:0] ex;
      string       n;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      #2;
      ex = exp_q.pop_front();
      n  = nm_q.pop_front();
      check_val(bus.dmDataR, ex, n);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      @(negedge clk);
      drive(a, d, 1'b1, sz, 1'b0);
      @(negedge clk);
      drive(a, 32'h0, 1'b0, SZ_W, 1'b0);
   endtask

   task automatic read_chk(input logic [31:0] a, input logic [2:0] sz, input logic sg,
                           input logic [31:0] e, input string nm);
      drive(a, 32'h0, 1'b0, sz, sg);
      expect_r(e, nm);
   endtask

   initial begin
      drive(32'h0, 32'h0, 1'b0, SZ_W, 1'b0);

      // Reset state, observed while rst_n is held low
      #2;
      check_val(32'(gpioOut), 32'h0, "reset_gpioOut");
      read_chk(32'h8008, SZ_W, 1'b0, 32'h0, "reset_timer");
      read_chk(32'h800C, SZ_W, 1'b0, 32'h0, "reset_status");
      @(negedge clk);
      rst_n = 1'b1;

      add(32'h10,   32'h11223344, 1, SZ_W, 0, 0, 0);
      add(32'h13,   0,            0, SZ_B, 1, 1, 32'h00000011);
      add(32'h12,   0,            0, SZ_H, 0, 1, 32'h00001122);
      add(32'h10,   0,            0, SZ_W, 0, 1, 32'h11223344);
      add(32'h10,   0,            0, SZ_N, 0, 1, 32'h11223344);
      add(32'h13,   0,            0, 3'b110, 0, 1, 32'h00000011);
      add(32'h410,  0,            0, SZ_W, 0, 1, 32'h11223344);
      add(32'h20,   32'h55667788, 1, SZ_W, 0, 0, 0);
      add(32'h21,   32'h12345680, 1, SZ_B, 0, 0, 0);
      add(32'h21,   0,            0, SZ_B, 1, 1, 32'hFFFFFF80);
      add(32'h21,   0,            0, SZ_B, 0, 1, 32'h00000080);
      add(32'h20,   0,            0, SZ_W, 0, 1, 32'h55668088);
      add(32'h30,   32'hCAFEF00D, 1, SZ_W, 0, 0, 0);
      add(32'h31,   32'h0000BEEF, 1, SZ_H, 0, 0, 0);
      add(32'h30,   0,            0, SZ_W, 0, 1, 32'hCAFEF00D);
      add(32'h800C, 0,            0, SZ_W, 0, 1, 32'h00000101);
      add(32'h31,   0,            0, SZ_H, 1, 1, 32'h00000000);
      add(32'h32,   0,            0, SZ_W, 0, 1, 32'h00000000);
      add(32'h32,   0,            0, SZ_H, 1, 1, 32'hFFFFCAFE);
      add(32'h32,   32'h1,        1, SZ_W, 0, 0, 0);
      add(32'h33,   32'h2,        1, SZ_H, 0, 0, 0);
      add(32'h35,   32'h3,        1, SZ_W, 0, 0, 0);
      add(32'h800C, 0,            0, SZ_W, 0, 1, 32'h00000401);
      add(32'h30,   0,            0, SZ_W, 0, 1, 32'hCAFEF00D);
      add(32'h800C, 32'h0,        1, SZ_W, 0, 0, 0);
      add(32'h800C, 0,            0, SZ_W, 0, 1, 32'h00000000);
      add(32'h8000, 32'h000000FF, 1, SZ_B, 0, 0, 0);
      add(32'h800C, 0,            0, SZ_W, 0, 1, 32'h00000000);
      add(32'h8000, 0,            0, SZ_W, 0, 1, 32'h00000000);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].sz, vecs[i].sg);
         if (vecs[i].chk) expect_r(vecs[i].exp, $sformatf("vec%0d", i));
      end
      @(negedge clk);
      drive(32'h0, 32'h0, 1'b0, SZ_W, 1'b0);

      // Timer: written value visible for one cycle, then counts and wraps
      store(32'h8008, 32'hFFFFFFFE, SZ_W);
      read_chk(32'h8008, SZ_W, 1'b0, 32'hFFFFFFFE, "timer_load");
      @(negedge clk);
      expect_r(32'hFFFFFFFF, "timer_inc");
      @(negedge clk);
      expect_r(32'h00000000, "timer_wrap");

      // GPIO input synchronizer and GPIO output register
      @(negedge clk);
      gpioIn = 16'hA5A5;
      read_chk(32'h8004, SZ_W, 1'b0, 32'h0, "gpioin_0edge");
      @(negedge clk);
      expect_r(32'h0, "gpioin_1edge");
      @(negedge clk);
      expect_r(32'h0000A5A5, "gpioin_2edge");
      read_chk(32'h8005, SZ_B, 1'b1, 32'hFFFFFFA5, "gpioin_byte_sext");
      store(32'h8000, 32'h1234ABCD, SZ_W);
      check_val(32'(gpioOut), 32'h0000ABCD, "gpioOut_word");
      read_chk(32'h8000, SZ_W, 1'b0, 32'h0000ABCD, "gpioout_read");
      store(32'h8000, 32'h00000055, SZ_B);
      check_val(32'(gpioOut), 32'h0000ABCD, "gpioOut_byte_ignored");

      // Mid-run asynchronous reset with nonzero timer and status
      store(32'h41, 32'h0, SZ_W);
      read_chk(32'h800C, SZ_W, 1'b0, 32'h00000101, "status_pre_reset");
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val(32'(gpioOut), 32'h0, "async_rst_gpioOut");
      read_chk(32'h8008, SZ_W, 1'b0, 32'h0, "async_rst_timer");
      read_chk(32'h800C, SZ_W, 1'b0, 32'h0, "async_rst_status");
      @(negedge clk);
      rst_n = 1'b1;

      // Unmapped space: store ignored, no fault, reads zero, no RAM alias
      store(32'h00010010, 32'hDEADBEEF, SZ_W);
      store(32'h00010011, 32'hDEADBEEF, SZ_W);
      read_chk(32'h00010010, SZ_W, 1'b0, 32'h0, "unmapped_read");
      read_chk(32'h800C, SZ_W, 1'b0, 32'h0, "unmapped_no_fault");
      read_chk(32'h10, SZ_W, 1'b0, 32'h11223344, "unmapped_no_alias");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
